ga23_row_shifter: RTL and testbench

//  Parametrised tile-row pixel shifter for the GA23 layer pipeline. Accepts planar

---
 rtl/ga23_row_shifter.sv | 166 ++++++++++++++++
 tb/tb_ga23_row_shifter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ga23_row_shifter.sv
// GA23 tile-row pixel shifter: queues planar tile rows, converts them to packed pixels at
// load time and shifts out one {palette,pixel} per pixel-clock enable with fine scroll.
`timescale 1ns/1ps
module ga23_row_shifter #(
    parameter int BPP    = 4,
    parameter int PIX    = 8,
    parameter int PAL_W  = 7,
    parameter int PRIO_W = 2,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce_pix,
    input  logic                     line_start,
    input  logic [$clog2(PIX)-1:0]   offset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     reverse,
    input  logic [BPP*PIX-1:0]       row,
    input  logic [PAL_W-1:0]         palette,
    input  logic [PRIO_W-1:0]        prio,
    output logic [PAL_W+BPP-1:0]     color_out,
    output logic [PRIO_W-1:0]        prio_out,
    output logic                     opaque_out,
    output logic                     underrun
);

    localparam int OFS_W = $clog2(PIX);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ROW_W = BPP * PIX;

    // Planar -> packed: pixel i (leftmost first) lands in bits [i*BPP +: BPP].
    function automatic logic [ROW_W-1:0] pack_row(input logic [ROW_W-1:0] planar,
                                                  input logic rev);
        logic [ROW_W-1:0] pk;
        pk = '0;
        for (int i = 0; i < PIX; i++) begin
            for (int p = 0; p < BPP; p++) begin
                pk[i*BPP+p] = rev ? planar[p*PIX+i] : planar[p*PIX+PIX-1-i];
            end
        end
        return pk;
    endfunction

    logic [ROW_W-1:0]  ent_pix_q  [DEPTH];
    logic [ROW_W-1:0]  ent_pix_d  [DEPTH];
    logic [PAL_W-1:0]  ent_pal_q  [DEPTH];
    logic [PAL_W-1:0]  ent_pal_d  [DEPTH];
    logic [PRIO_W-1:0] ent_prio_q [DEPTH];
    logic [PRIO_W-1:0] ent_prio_d [DEPTH];

    logic [CNT_W-1:0]  count_q,    count_d;
    logic [OFS_W-1:0]  cnt_q,      cnt_d;
    logic [ROW_W-1:0]  pix_cur_q,  pix_cur_d;
    logic [PAL_W-1:0]  pal_cur_q,  pal_cur_d;
    logic [PRIO_W-1:0] prio_cur_q, prio_cur_d;
    logic              underrun_q, underrun_d;

    logic [OFS_W-1:0]  pos;
    logic              step;
    logic              pop_req;
    logic              q_empty;
    logic              do_pop;
    logic              push;
    logic [CNT_W-1:0]  wr_idx;
    logic [ROW_W-1:0]  row_packed;

    assign load_ready = (count_q < CNT_W'(DEPTH));
    assign pos        = cnt_q + offset;
    assign step       = ce_pix && !line_start;
    assign pop_req    = step && (pos == OFS_W'(PIX - 1));
    assign q_empty    = (count_q == '0);
    assign do_pop     = pop_req && !q_empty;
    assign push       = load_valid && load_ready && !line_start;
    // The popped head vacates slot 0, so a simultaneous push lands one slot lower.
    assign wr_idx     = do_pop ? (count_q - CNT_W'(1)) : count_q;
    assign row_packed = pack_row(row, reverse);

    always_comb begin
        ent_pix_d  = ent_pix_q;
        ent_pal_d  = ent_pal_q;
        ent_prio_d = ent_prio_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        pix_cur_d  = pix_cur_q;
        pal_cur_d  = pal_cur_q;
        prio_cur_d = prio_cur_q;
        underrun_d = pop_req && q_empty;

        if (line_start) begin
            count_d    = '0;
            cnt_d      = '0;
            pix_cur_d  = '0;
            pal_cur_d  = '0;
            prio_cur_d = '0;
        end else begin
            if (step) begin
                cnt_d = cnt_q + OFS_W'(1);
            end

            if (pop_req) begin
                if (q_empty) begin
                    pix_cur_d = '0;
                end else begin
                    pix_cur_d  = ent_pix_q[0];
                    pal_cur_d  = ent_pal_q[0];
                    prio_cur_d = ent_prio_q[0];
                end
            end else if (step) begin
                pix_cur_d = pix_cur_q >> BPP;
            end

            if (do_pop) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    ent_pix_d[k]  = ent_pix_q[k+1];
                    ent_pal_d[k]  = ent_pal_q[k+1];
                    ent_prio_d[k] = ent_prio_q[k+1];
                end
            end

            if (push) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (CNT_W'(k) == wr_idx) begin
                        ent_pix_d[k]  = row_packed;
                        ent_pal_d[k]  = palette;
                        ent_prio_d[k] = prio;
                    end
                end
            end

            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_pix_q[k]  <= '0;
                ent_pal_q[k]  <= '0;
                ent_prio_q[k] <= '0;
            end
            count_q    <= '0;
            cnt_q      <= '0;
            pix_cur_q  <= '0;
            pal_cur_q  <= '0;
            prio_cur_q <= '0;
            underrun_q <= 1'b0;
        end else begin
            ent_pix_q  <= ent_pix_d;
            ent_pal_q  <= ent_pal_d;
            ent_prio_q <= ent_prio_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            pix_cur_q  <= pix_cur_d;
            pal_cur_q  <= pal_cur_d;
            prio_cur_q <= prio_cur_d;
            underrun_q <= underrun_d;
        end
    end

    assign color_out  = {pal_cur_q, pix_cur_q[BPP-1:0]};
    assign prio_out   = prio_cur_q;
    assign opaque_out = |pix_cur_q[BPP-1:0];
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_ga23_row_shifter.sv
// Bench for ga23_row_shifter: directed scenarios followed by random traffic, all checked
// against a pixel-list/queue reference model every cycle.
`timescale 1ns/1ps
module tb_ga23_row_shifter;

    localparam int BPP    = 4;
    localparam int PIX    = 8;
    localparam int PAL_W  = 7;
    localparam int PRIO_W = 2;
    localparam int DEPTH  = 2;
    localparam int OFS_W  = $clog2(PIX);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 ce_pix;
    logic                 line_start;
    logic [OFS_W-1:0]     offset;
    logic                 load_valid;
    logic                 load_ready;
    logic                 reverse;
    logic [BPP*PIX-1:0]   row;
    logic [PAL_W-1:0]     palette;
    logic [PRIO_W-1:0]    prio;
    logic [PAL_W+BPP-1:0] color_out;
    logic [PRIO_W-1:0]    prio_out;
    logic                 opaque_out;
    logic                 underrun;

    ga23_row_shifter #(
        .BPP(BPP), .PIX(PIX), .PAL_W(PAL_W), .PRIO_W(PRIO_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .line_start(line_start),
        .offset(offset), .load_valid(load_valid), .load_ready(load_ready),
        .reverse(reverse), .row(row), .palette(palette), .prio(prio),
        .color_out(color_out), .prio_out(prio_out), .opaque_out(opaque_out),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PIX-1:0][BPP-1:0] px;
        logic [PAL_W-1:0]        pal;
        logic [PRIO_W-1:0]       pr;
    } ent_t;

    // Reference model: a queue of pixel lists and the list currently on screen.
    ent_t                    mq[$];
    logic [PIX-1:0][BPP-1:0] m_cur;
    logic [PAL_W-1:0]        m_pal;
    logic [PRIO_W-1:0]       m_prio;
    logic                    m_und;
    int                      m_cnt;

    // Intended left-to-right pixel values of the offered row (unflipped).
    logic [PIX-1:0][BPP-1:0] px_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_row();
        for (int i = 0; i < PIX; i++)
            for (int p = 0; p < BPP; p++)
                row[p*PIX+PIX-1-i] = px_in[i][p];
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur  = '0;
        m_pal  = '0;
        m_prio = '0;
        m_und  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit   ready;
        ent_t e;
        ready = (mq.size() < DEPTH);
        if (line_start) begin
            model_reset();
        end else begin
            m_und = 1'b0;
            if (ce_pix) begin
                if (((m_cnt + int'(offset)) % PIX) == PIX - 1) begin
                    if (mq.size() == 0) begin
                        m_cur = '0;
                        m_und = 1'b1;
                    end else begin
                        e      = mq.pop_front();
                        m_cur  = e.px;
                        m_pal  = e.pal;
                        m_prio = e.pr;
                    end
                end else begin
                    for (int i = 0; i < PIX - 1; i++) m_cur[i] = m_cur[i+1];
                    m_cur[PIX-1] = '0;
                end
                m_cnt = (m_cnt + 1) % PIX;
            end
            if (load_valid && ready) begin
                for (int i = 0; i < PIX; i++)
                    e.px[i] = reverse ? px_in[PIX-1-i] : px_in[i];
                e.pal = palette;
                e.pr  = prio;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        chk("color",  32'(color_out),  32'({m_pal, m_cur[0]}));
        chk("prio",   32'(prio_out),   32'(m_prio));
        chk("opaque", 32'(opaque_out), 32'(|m_cur[0]));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("ready",  32'(load_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic tick(input bit ce, input bit ls, input bit lv);
        ce_pix     = ce;
        line_start = ls;
        load_valid = lv;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_color"},  32'(color_out),  32'h0);
        chk({tag, "_prio"},   32'(prio_out),   32'h0);
        chk({tag, "_opaque"}, 32'(opaque_out), 32'h0);
        chk({tag, "_und"},    32'(underrun),   32'h0);
        chk({tag, "_ready"},  32'(load_ready), 32'h1);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < PIX; i++) px_in[i] = BPP'($urandom_range(0, (1 << BPP) - 1));
        build_row();
        reverse = 1'($urandom_range(0, 1));
        palette = PAL_W'($urandom);
        prio    = PRIO_W'($urandom);
        if ($urandom_range(0, 49) == 0) offset = OFS_W'($urandom);
    endtask

    initial begin
        reset_n = 1'b0; ce_pix = 0; line_start = 0; offset = '0; load_valid = 0;
        reverse = 0; row = '0; palette = '0; prio = '0; px_in = '0;
        model_reset();
        #12;
        check_reset_outputs("rst_init");
        @(negedge clk);
        reset_n = 1'b1;

        // Order + flip + backpressure: two rows queued, third push stalls.
        tick(0, 1, 0);
        for (int i = 0; i < PIX; i++) px_in[i] = BPP'(i + 1);
        build_row();
        palette = 7'h15; prio = 2'd2; reverse = 0;
        tick(0, 0, 1);
        reverse = 1; prio = 2'd1;
        tick(0, 0, 1);
        chk("bp_full_ready", 32'(load_ready), 32'h0);
        reverse = 0; palette = 7'h2a;
        tick(0, 0, 1);
        chk("bp_stall_ready", 32'(load_ready), 32'h0);
        for (int k = 0; k < 7; k++) tick(1, 0, 0);
        for (int k = 0; k < PIX; k++) begin
            tick(1, 0, 0);
            chk("order", 32'(color_out), 32'({7'h15, 4'(k + 1)}));
            if (k == 0) chk("bp_ready_after_pop", 32'(load_ready), 32'h1);
        end
        for (int k = 0; k < PIX; k++) begin
            tick(1, 0, 0);
            chk("flip", 32'(color_out), 32'({7'h15, 4'(PIX - k)}));
        end
        tick(1, 0, 0);
        chk("und_pulse", 32'(underrun), 32'h1);
        chk("und_color", 32'(color_out), 32'h150);
        chk("und_opaque", 32'(opaque_out), 32'h0);
        tick(1, 0, 0);
        chk("und_clear", 32'(underrun), 32'h0);

        // Fine scroll: offset 3 pops on the 5th enable after line_start.
        offset = 3'd3;
        tick(0, 1, 0);
        for (int i = 0; i < PIX; i++) px_in[i] = BPP'(15 - i);
        build_row();
        palette = 7'h33; prio = 2'd3; reverse = 0;
        tick(0, 0, 1);
        tick(0, 0, 1);
        for (int k = 0; k < 4; k++) tick(1, 0, 0);
        chk("ofs_before", 32'(color_out), 32'h0);
        tick(1, 0, 0);
        chk("ofs_pop", 32'(color_out), 32'({7'h33, 4'hf}));
        for (int k = 0; k < 7; k++) tick(1, 0, 0);
        tick(1, 0, 0);
        chk("ofs_second_pop", 32'(color_out), 32'({7'h33, 4'hf}));

        // Flush with two rows queued; the push on the flush cycle is dropped.
        tick(0, 0, 1);
        tick(0, 0, 1);
        tick(0, 1, 1);
        chk("flush_ready", 32'(load_ready), 32'h1);
        chk("flush_color", 32'(color_out), 32'h0);
        chk("flush_prio", 32'(prio_out), 32'h0);
        tick(1, 0, 0);

        // Random traffic, then an asynchronous reset mid-stream, then more traffic.
        offset = '0;
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0));
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
